// File: rtl/gemm_pkg.sv
// gemm_pkg: types and constants shared by the GeMM blocks.
//   writer_state_t : result-writer FSM state encoding
//   SizeWidth      : width of matrix size ports (sizes up to 32, inclusive)
package gemm_pkg;

  localparam int SizeWidth = $clog2(32) + 1;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_DRAIN  = 2'd1,
    WR_FINISH = 2'd2
  } writer_state_t;

endpackage

// File: rtl/gemm_tile_fifo.sv
// gemm_tile_fifo: synchronous FIFO holding whole result tiles.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : synchronous flush (empties the FIFO)
//   push_i, wdata_i : write one entry (caller guarantees room or a same-cycle pop)
//   pop_i           : drop the head entry (caller guarantees non-empty)
//   rdata_o         : head entry, valid while !empty_o
//   full_o, empty_o : occupancy flags
module gemm_tile_fifo #(
  parameter int Width = 512,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrWidth = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PtrWidth:0] r_wr_ptr;
  logic [PtrWidth:0] r_rd_ptr;
  logic [Width-1:0]  r_mem [Depth];

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[PtrWidth] != r_rd_ptr[PtrWidth]) &&
                   (r_wr_ptr[PtrWidth-1:0] == r_rd_ptr[PtrWidth-1:0]);
  assign rdata_o = r_mem[r_rd_ptr[PtrWidth-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  // A push into a full FIFO with a same-cycle pop overwrites the slot being
  // popped, which is safe because the head is read combinationally.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr[PtrWidth-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/gemm_result_writer.sv
// gemm_result_writer: buffers M x N result tiles from the MAC array and writes
// them row by row into the output SRAM in row-major word order. Tiles are
// expected in controller order (tile column tn inner, tile row tm outer).
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   start_i               : begin a matrix (Idle only); sizes sampled this cycle
//   M_size_i, N_size_i    : rows / columns of C
//   result_valid_i        : tile present on result_i
//   result_i              : tile, element (r,c) at [(r*N+c)*DataWidth +: DataWidth]
//   result_ready_o        : buffer can take a tile this cycle
//   sram_we_o             : write request
//   sram_addr_o           : word address
//   sram_wdata_o          : one tile row
//   sram_ready_i          : SRAM accepts the write this cycle
//   busy_o                : Drain or Finish
//   done_o                : one-cycle pulse after the last write
//   overflow_o            : sticky, a tile was dropped while draining
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (result_valid_i/result_ready_o, sram_we_o/sram_ready_i). Once
// sram_we_o is raised, address and data are held until sram_ready_i is seen.
module gemm_result_writer
  import gemm_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int AddrWidth = 8,
  parameter int Depth     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeWidth-1:0]     M_size_i,
  input  logic [SizeWidth-1:0]     N_size_i,
  input  logic                     result_valid_i,
  input  logic [M*N*DataWidth-1:0] result_i,
  output logic                     result_ready_o,
  output logic                     sram_we_o,
  output logic [AddrWidth-1:0]     sram_addr_o,
  output logic [N*DataWidth-1:0]   sram_wdata_o,
  input  logic                     sram_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overflow_o
);

  localparam int TileWidth   = M * N * DataWidth;
  localparam int RowWidth    = N * DataWidth;
  localparam int RowCntWidth = (M > 1) ? $clog2(M) : 1;

  writer_state_t r_state;
  writer_state_t w_state_next;

  logic [SizeWidth-1:0]   r_tiles_m;
  logic [SizeWidth-1:0]   r_tiles_n;
  logic [SizeWidth-1:0]   r_tm;
  logic [SizeWidth-1:0]   r_tn;
  logic [RowCntWidth-1:0] r_row;
  logic                   r_overflow;

  logic                 w_start;
  logic                 w_in_drain;
  logic                 w_degenerate;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [TileWidth-1:0] w_head;
  logic [RowWidth-1:0]  w_row_data;
  logic                 w_we;
  logic                 w_accept;
  logic                 w_last_row;
  logic                 w_last_tn;
  logic                 w_last_tm;
  logic                 w_pop;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_drop;
  logic [11:0]          w_row_index;
  logic [11:0]          w_addr_full;

  assign w_start      = start_i && (r_state == WR_IDLE);
  assign w_in_drain   = (r_state == WR_DRAIN);
  assign w_degenerate = (r_tiles_m == '0) || (r_tiles_n == '0);

  // A zero-tile matrix never writes, even if a tile sneaks into the buffer.
  assign w_we       = w_in_drain && !w_fifo_empty && !w_degenerate;
  assign w_accept   = w_we && sram_ready_i;
  assign w_last_row = (r_row == RowCntWidth'(M - 1));
  assign w_last_tn  = (r_tn == r_tiles_n - SizeWidth'(1));
  assign w_last_tm  = (r_tm == r_tiles_m - SizeWidth'(1));
  assign w_pop      = w_accept && w_last_row;

  // Ready while there is room, or when the head leaves in this same cycle.
  // Tiles are only stored while draining; elsewhere they are silently lost.
  assign w_ready = !w_fifo_full || w_pop;
  assign w_push  = result_valid_i && w_ready && w_in_drain;
  assign w_drop  = result_valid_i && !w_ready && w_in_drain;

  gemm_tile_fifo #(
    .Width(TileWidth),
    .Depth(Depth)
  ) u_tile_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(w_start),
    .push_i (w_push),
    .wdata_i(result_i),
    .pop_i  (w_pop),
    .rdata_o(w_head),
    .full_o (w_fifo_full),
    .empty_o(w_fifo_empty)
  );

  // Row-major word address: global row (tm*M + r) times words per row
  // (tilesN), plus the tile column. Computed at 12 bits, then truncated.
  assign w_row_index = 12'(r_tm) * 12'(M) + 12'(r_row);
  assign w_addr_full = w_row_index * 12'(r_tiles_n) + 12'(r_tn);
  assign w_row_data  = w_head[r_row * RowWidth +: RowWidth];

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= WR_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WR_IDLE: begin
        if (start_i) w_state_next = WR_DRAIN;
      end
      WR_DRAIN: begin
        if (w_degenerate) begin
          w_state_next = WR_FINISH;
        end else if (w_pop && w_last_tn && w_last_tm) begin
          w_state_next = WR_FINISH;
        end
      end
      WR_FINISH: w_state_next = WR_IDLE;
      default:   w_state_next = WR_IDLE;
    endcase
  end

  // Matrix geometry, tile/row counters and the sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tiles_m  <= '0;
      r_tiles_n  <= '0;
      r_tm       <= '0;
      r_tn       <= '0;
      r_row      <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_tiles_m  <= M_size_i / SizeWidth'(M);
      r_tiles_n  <= N_size_i / SizeWidth'(N);
      r_tm       <= '0;
      r_tn       <= '0;
      r_row      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last_row) begin
          r_row <= '0;
          if (w_last_tn) begin
            r_tn <= '0;
            r_tm <= r_tm + 1'b1;
          end else begin
            r_tn <= r_tn + 1'b1;
          end
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign result_ready_o = w_ready;
  assign sram_we_o      = w_we;
  assign sram_addr_o    = AddrWidth'(w_addr_full);
  // Gated so the bus reads zero whenever no write is being requested.
  assign sram_wdata_o   = w_we ? w_row_data : '0;
  assign busy_o         = (r_state != WR_IDLE);
  assign done_o         = (r_state == WR_FINISH);
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_gemm_result_writer.sv
// tb_gemm_result_writer: directed scenarios with random tile contents, checked
// against a reference list of (address, row) writes built from the matrix
// geometry.
module tb_gemm_result_writer;

  localparam int DW    = 32;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 2;
  localparam int TW    = M * N * DW;
  localparam int RW    = N * DW;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [5:0]    m_size = '0;
  logic [5:0]    n_size = '0;
  logic          result_valid_i = 1'b0;
  logic [TW-1:0] result_i = '0;
  logic          result_ready_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [RW-1:0] sram_wdata_o;
  logic          sram_ready_i = 1'b1;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  gemm_result_writer #(
    .DataWidth(DW),
    .M(M),
    .N(N),
    .AddrWidth(AW),
    .Depth(DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .M_size_i      (m_size),
    .N_size_i      (n_size),
    .result_valid_i(result_valid_i),
    .result_i      (result_i),
    .result_ready_o(result_ready_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_ready_i  (sram_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_fail = 0;
  int n_writes = 0;
  int n_done = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  logic [AW-1:0] exp_q[$];
  logic [RW-1:0] exp_data_q[$];
  logic [AW-1:0] obs_addr_q[$];
  logic [TW-1:0] tiles[4];

  int s1_addrs[16] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every accepted write must be the next entry of the reference list.
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && sram_we_o === 1'b1 && sram_ready_i === 1'b1) begin
      n_writes++;
      last_wr_cyc = cyc;
      obs_addr_q.push_back(sram_addr_o);
      check("write_expected", RW'(exp_q.size() != 0), RW'(1));
      if (exp_q.size() != 0) begin
        check("wr_addr", RW'(sram_addr_o), RW'(exp_q.pop_front()));
        check("wr_data", sram_wdata_o, exp_data_q.pop_front());
      end
    end
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // Reference model: C is (ms x ns), stored row-major, one SRAM word per
  // N columns. Tile k sits at tile row k / tilesN, tile column k % tilesN.
  task automatic build_exp(input int ms, input int ns, input int ntiles);
    int tiles_n;
    int tm;
    int tn;
    int word;
    tiles_n = ns / N;
    for (int k = 0; k < ntiles; k++) begin
      tm = k / tiles_n;
      tn = k % tiles_n;
      for (int r = 0; r < M; r++) begin
        word = ((tm * M + r) * tiles_n + tn) % (1 << AW);
        exp_q.push_back(AW'(word));
        exp_data_q.push_back(tiles[k][r * RW +: RW]);
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_tiles();
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < M * N; w++)
        tiles[k][w * DW +: DW] = $urandom;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"}, RW'(sram_we_o), RW'(0));
    check({tag, "_addr"}, RW'(sram_addr_o), RW'(0));
    check({tag, "_wdata"}, sram_wdata_o, RW'(0));
    check({tag, "_busy"}, RW'(busy_o), RW'(0));
    check({tag, "_done"}, RW'(done_o), RW'(0));
    check({tag, "_ovf"}, RW'(overflow_o), RW'(0));
    check({tag, "_ready"}, RW'(result_ready_o), RW'(1));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    start_i = 1'b0;
    result_valid_i = 1'b0;
    sram_ready_i = 1'b1;
    exp_q.delete();
    exp_data_q.delete();
    #1;
    check_reset("reset");
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic do_start(input int ms, input int ns);
    start_i = 1'b1;
    m_size = 6'(ms);
    n_size = 6'(ns);
    step();
    start_i = 1'b0;
  endtask

  task automatic push_then(input int k, input int idle);
    result_valid_i = 1'b1;
    result_i = tiles[k];
    step();
    result_valid_i = 1'b0;
    repeat (idle) step();
  endtask

  task automatic wait_done(input int budget, input int base);
    for (int i = 0; i < budget && n_done == base; i++) step();
    check("done_timeout", RW'(n_done > base), RW'(1));
  endtask

  // Full 8x8 matrix, optionally with a 5-cycle SRAM stall inside tile 0.
  task automatic run_full(input string tag, input bit stall);
    int w0;
    int d0;
    w0 = n_writes;
    d0 = n_done;
    gen_tiles();
    obs_addr_q.delete();
    build_exp(8, 8, 4);
    do_start(8, 8);
    result_valid_i = 1'b1;
    result_i = tiles[0];
    @(negedge clk);
    check({tag, "_busy"}, RW'(busy_o), RW'(1));
    check({tag, "_we_empty"}, RW'(sram_we_o), RW'(0));
    check({tag, "_ready"}, RW'(result_ready_o), RW'(1));
    step();
    result_valid_i = 1'b0;
    @(negedge clk);
    check({tag, "_latency"}, RW'(sram_we_o), RW'(1));
    if (stall) begin
      step();
      step();
      sram_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check({tag, "_stall_we"}, RW'(sram_we_o), RW'(1));
        check({tag, "_stall_addr"}, RW'(sram_addr_o), RW'(exp_q[0]));
        check({tag, "_stall_data"}, sram_wdata_o, exp_data_q[0]);
        step();
      end
      sram_ready_i = 1'b1;
      for (int k = 1; k < 4; k++) push_then(k, 7);
    end else begin
      step();
      step();
      step();
      for (int k = 1; k < 4; k++) push_then(k, 3);
    end
    wait_done(80, d0);
    step();
    step();
    check({tag, "_writes"}, RW'(n_writes - w0), RW'(16));
    check({tag, "_done_count"}, RW'(n_done - d0), RW'(1));
    check({tag, "_done_timing"}, RW'(done_cyc), RW'(last_wr_cyc + 1));
    check({tag, "_exp_left"}, RW'(exp_q.size()), RW'(0));
    check({tag, "_ovf"}, RW'(overflow_o), RW'(0));
    check({tag, "_idle"}, RW'(busy_o), RW'(0));
    if (obs_addr_q.size() == 16)
      for (int i = 0; i < 16; i++)
        check({tag, "_addr_order"}, RW'(obs_addr_q[i]), RW'(s1_addrs[i]));
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int w0;
    int d0;

    do_reset();

    // Full matrix, no backpressure
    run_full("s1", 1'b0);

    // Backpressure mid-tile
    run_full("s2", 1'b1);

    // Buffer full: three back-to-back tiles with the SRAM stalled
    w0 = n_writes;
    d0 = n_done;
    gen_tiles();
    build_exp(8, 8, 2);
    do_start(8, 8);
    sram_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      result_valid_i = 1'b1;
      result_i = tiles[k];
      @(negedge clk);
      check("s3_ready", RW'(result_ready_o), RW'(k < 2));
      step();
    end
    result_valid_i = 1'b0;
    @(negedge clk);
    check("s3_ovf_set", RW'(overflow_o), RW'(1));
    check("s3_full", RW'(result_ready_o), RW'(0));
    sram_ready_i = 1'b1;
    repeat (16) step();
    check("s3_writes", RW'(n_writes - w0), RW'(8));
    check("s3_exp_left", RW'(exp_q.size()), RW'(0));
    check("s3_no_done", RW'(n_done - d0), RW'(0));
    check("s3_ovf_sticky", RW'(overflow_o), RW'(1));
    check("s3_still_busy", RW'(busy_o), RW'(1));
    do_reset();

    // Push on a full buffer in the cycle its head tile leaves
    w0 = n_writes;
    d0 = n_done;
    gen_tiles();
    build_exp(8, 8, 4);
    do_start(8, 8);
    push_then(0, 0);
    push_then(1, 2);
    result_valid_i = 1'b1;
    result_i = tiles[2];
    @(negedge clk);
    check("s4_ready_full_pop", RW'(result_ready_o), RW'(1));
    step();
    result_valid_i = 1'b0;
    @(negedge clk);
    check("s4_occupancy2", RW'(result_ready_o), RW'(0));
    check("s4_ovf", RW'(overflow_o), RW'(0));
    step();
    step();
    step();
    result_valid_i = 1'b1;
    result_i = tiles[3];
    @(negedge clk);
    check("s4_ready_second_pop", RW'(result_ready_o), RW'(1));
    step();
    result_valid_i = 1'b0;
    wait_done(60, d0);
    check("s4_writes", RW'(n_writes - w0), RW'(16));
    check("s4_exp_left", RW'(exp_q.size()), RW'(0));
    check("s4_ovf_end", RW'(overflow_o), RW'(0));

    // Degenerate size: tilesM = 0
    w0 = n_writes;
    d0 = n_done;
    do_start(2, 8);
    result_valid_i = 1'b1;
    result_i = tiles[0];
    @(negedge clk);
    check("s5_busy", RW'(busy_o), RW'(1));
    check("s5_done_early", RW'(done_o), RW'(0));
    check("s5_we", RW'(sram_we_o), RW'(0));
    step();
    result_valid_i = 1'b0;
    @(negedge clk);
    check("s5_done", RW'(done_o), RW'(1));
    check("s5_we_finish", RW'(sram_we_o), RW'(0));
    step();
    @(negedge clk);
    check("s5_done_pulse", RW'(done_o), RW'(0));
    check("s5_idle", RW'(busy_o), RW'(0));
    check("s5_writes", RW'(n_writes - w0), RW'(0));
    check("s5_done_count", RW'(n_done - d0), RW'(1));
    step();

    // Reset after three writes, then a clean full run
    w0 = n_writes;
    gen_tiles();
    build_exp(8, 8, 1);
    do_start(8, 8);
    push_then(0, 0);
    for (int i = 0; i < 20 && (n_writes - w0) < 3; i++) step();
    check("s6_three_writes", RW'(n_writes - w0), RW'(3));
    do_reset();
    run_full("s6", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
